// File: rtl/sbox.sv
// AES forward S-box, purely combinational, one byte in and one byte out.
// The multiplicative inverse in GF(2^8) is formed as x^254, so 0 maps to 0.
// The standard affine transform is then applied to that inverse.
//   data_i : input byte
//   data_o : substituted byte
module sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // GF(2^8) multiply, reduced by the AES polynomial 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] pow_sq;
  logic [7:0] inv;

  always_comb begin
    // Build x^254 as x^2 * x^4 * ... * x^128.
    pow_sq = gf_mul(data_i, data_i);
    inv    = pow_sq;
    for (int i = 0; i < 6; i++) begin
      pow_sq = gf_mul(pow_sq, pow_sq);
      inv    = gf_mul(inv, pow_sq);
    end
    data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/key_expander.sv
// Round-key generator for the 15-entry key store.
// A start pulse in IDLE latches the cipher key and clears the store's valid bits for one cycle.
// It then writes one 128-bit round key per cycle to addresses 0..N and pulses done.
// N is 10 for AES-128 and 14 for AES-256.
// Build option: define KEYEXP_AES256_EN to honour key_len and build AES-256 expansion.
// Without it, key_len is ignored and only key_in[255:128] is used.
//   clk              : clock, rising edge
//   reset            : asynchronous active-low reset
//   start            : one-cycle request, accepted only in IDLE
//   key_len          : 0 = AES-128, 1 = AES-256, sampled with start
//   key_in           : cipher key, word w0 = key_in[255:224]
//   w_en             : key-memory write enable
//   waddr            : key-memory write address (round index)
//   wkey             : round key, wkey[127:96] is the first word
//   reset_valid_bits : one-cycle clear of the key-memory valid bits
//   busy             : high from acceptance until return to IDLE
//   done             : one-cycle pulse after the last write
// All outputs are registered.
module key_expander (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         key_len,
  input  logic [255:0] key_in,
  output logic         w_en,
  output logic [3:0]   waddr,
  output logic [127:0] wkey,
  output logic         reset_valid_bits,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StClear, StExpand, StDone} state_e;

`ifdef KEYEXP_AES256_EN
  localparam int unsigned KeyW = 256;
`else
  localparam int unsigned KeyW = 128;
`endif

  state_e          state_q;
  logic [KeyW-1:0] key_q;
  logic [KeyW-1:0] key_d;
  logic [3:0]      cnt_q;
  logic [7:0]      rcon_q;
  logic [7:0]      rcon_d;
  logic            aes256;
  logic [3:0]      last_round;
  logic            use_rot;
  logic [31:0]     last_word;
  logic [31:0]     sub_in;
  logic [31:0]     sub_out;
  logic [31:0]     t_word;
  logic [31:0]     n0, n1, n2, n3;
  logic [127:0]    cur_key;

`ifdef KEYEXP_AES256_EN
  logic aes256_q;
  assign aes256 = aes256_q;
`else
  assign aes256 = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{key_len, key_in[127:0]};
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_sbox
    sbox u_sbox (
      .data_i (sub_in[8*g +: 8]),
      .data_o (sub_out[8*g +: 8])
    );
  end

  // The working register is a sliding window whose top 128 bits are always the key written next.
  // AES-128 holds {rk(i)}.
  // AES-256 holds {rk(i), rk(i+1)} and computes rk(i+2) from it.
  // Even targets of AES-256 use rotate+Rcon; odd targets use a plain SubWord.
  always_comb begin
    cur_key    = key_q[KeyW-1 -: 128];
    last_round = aes256 ? 4'd14 : 4'd10;
`ifdef KEYEXP_AES256_EN
    last_word  = aes256 ? key_q[31:0] : key_q[159:128];
    use_rot    = !aes256 || !cnt_q[0];
`else
    last_word  = key_q[31:0];
    use_rot    = 1'b1;
`endif
    sub_in     = use_rot ? {last_word[23:0], last_word[31:24]} : last_word;
    t_word     = sub_out ^ (use_rot ? {rcon_q, 24'h000000} : 32'h0);
    n0         = cur_key[127:96] ^ t_word;
    n1         = cur_key[95:64]  ^ n0;
    n2         = cur_key[63:32]  ^ n1;
    n3         = cur_key[31:0]   ^ n2;
    rcon_d     = use_rot ? xtime(rcon_q) : rcon_q;
`ifdef KEYEXP_AES256_EN
    key_d      = aes256 ? {key_q[127:0], n0, n1, n2, n3} : {n0, n1, n2, n3, key_q[127:0]};
`else
    key_d      = {n0, n1, n2, n3};
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      key_q            <= '0;
      cnt_q            <= 4'd0;
      rcon_q           <= 8'h01;
`ifdef KEYEXP_AES256_EN
      aes256_q         <= 1'b0;
`endif
      w_en             <= 1'b0;
      waddr            <= 4'd0;
      wkey             <= '0;
      reset_valid_bits <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      w_en             <= 1'b0;
      reset_valid_bits <= 1'b0;
      done             <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            key_q            <= key_in[255 -: KeyW];
`ifdef KEYEXP_AES256_EN
            aes256_q         <= key_len;
`endif
            cnt_q            <= 4'd0;
            rcon_q           <= 8'h01;
            reset_valid_bits <= 1'b1;
            busy             <= 1'b1;
            state_q          <= StClear;
          end
        end
        StClear, StExpand: begin
          // CLEAR's edge issues write 0, so the clear pulse and w_en never overlap.
          if (state_q == StExpand && waddr == last_round) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            w_en    <= 1'b1;
            waddr   <= cnt_q;
            wkey    <= cur_key;
            key_q   <= key_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_q + 4'd1;
            state_q <= StExpand;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expander.sv
module tb_key_expander;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         key_len = 1'b0;
  logic [255:0] key_in = '0;
  logic         w_en;
  logic [3:0]   waddr;
  logic [127:0] wkey;
  logic         reset_valid_bits;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail = 0;

`ifdef KEYEXP_AES256_EN
  localparam bit HasAes256 = 1'b1;
`else
  localparam bit HasAes256 = 1'b0;
`endif

  typedef logic [14:0][127:0] rk_set_t;

  logic [7:0] sb [256];
  int         phase = 0;
  int         m_last = 10;
  rk_set_t    m_rk;

  key_expander dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .key_len          (key_len),
    .key_in           (key_in),
    .w_en             (w_en),
    .waddr            (waddr),
    .wkey             (wkey),
    .reset_valid_bits (reset_valid_bits),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Textbook word-oriented key schedule.
  function automatic rk_set_t expand(input logic [255:0] k, input bit aes);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rc;
    int          nk;
    int          nr;
    rk_set_t     r;
    nk = aes ? 8 : 4;
    nr = aes ? 14 : 10;
    rc = 8'h01;
    r  = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        temp = subw(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int j = 0; j <= nr; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Timeline model: phase = cycles since acceptance (0 = idle).
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= 0;
    end else if (phase == 0) begin
      if (start) begin
        m_rk   <= expand(key_in, key_len && HasAes256);
        m_last <= (key_len && HasAes256) ? 14 : 10;
        phase  <= 1;
      end
    end else if (phase == m_last + 3) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_w_en", 128'(w_en), 128'(0));
      check("rst_waddr", 128'(waddr), 128'(0));
      check("rst_wkey", wkey, 128'(0));
      check("rst_clear", 128'(reset_valid_bits), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
    end else begin
      check("busy", 128'(busy), 128'(phase != 0));
      check("reset_valid_bits", 128'(reset_valid_bits), 128'(phase == 1));
      check("w_en", 128'(w_en), 128'(phase >= 2 && phase <= m_last + 2));
      check("done", 128'(done), 128'(phase == m_last + 3));
      check("clear_write_excl", 128'(reset_valid_bits & w_en), 128'(0));
      if (phase >= 2 && phase <= m_last + 2) begin
        check("waddr", 128'(waddr), 128'(phase - 2));
        check("wkey", wkey, m_rk[phase-2]);
        check("waddr_max", 128'(int'(waddr) > (HasAes256 ? 14 : 10)), 128'(0));
      end
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (phase != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("idle_timeout", 128'(phase != 0), 128'(0));
  endtask

  task automatic launch(input logic [255:0] k, input logic len);
    key_in  = k;
    key_len = len;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    key_in  = rand256();
    key_len = 1'($urandom_range(0, 1));
  endtask

  // Returns at the negedge on which done is seen.
  task automatic wait_done(input int exp_lat, input bit inject, input string name);
    int lat;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (inject && c == 4) begin
        start   = 1'b1;
        key_in  = rand256();
        key_len = 1'($urandom_range(0, 1));
      end
      if (inject && c == 5) start = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    check(name, 128'(lat), 128'(exp_lat));
  endtask

  logic [255:0] k128;
  logic [255:0] k256;
  rk_set_t      r;

  initial begin
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    bit         len;
    // S-box from the 3 / 3^-1 generator walk.
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    check("model_sbox_00", 128'(sb[0]), 128'(8'h63));
    check("model_sbox_53", 128'(sb[8'h53]), 128'(8'hed));

    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    r = expand(k128, 1'b0);
    check("model_a1_rk0", r[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("model_a1_rk1", r[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_a1_rk10", r[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef KEYEXP_AES256_EN
    r = expand(k256, 1'b1);
    check("model_a3_rk1", r[1], 128'h1f352c073b6108d72d9810a30914dff4);
    check("model_a3_rk2", r[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    check("model_a3_rk14", r[14], 128'hfe4890d1e6188d0b046df344706c631e);
`endif

    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // FIPS-197 A.1
    wait_idle();
    launch(k128, 1'b0);
    wait_done(13, 1'b0, "a1_done_latency");

    // FIPS-197 A.3 with a stray start during expansion
    wait_idle();
    launch(k256, 1'b1);
    wait_done(HasAes256 ? 17 : 13, 1'b1, "a3_done_latency");

    // Back-to-back: start held from the DONE cycle into the first IDLE cycle.
    start   = 1'b1;
    key_in  = k128;
    key_len = 1'b0;
    @(posedge clk);
    #1;
    launch(k128, 1'b0);
    wait_done(13, 1'b0, "b2b_done_latency");

    // Reset in the middle of EXPAND
    wait_idle();
    launch(k256, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_w_en", 128'(w_en), 128'(0));
    check("mid_reset_busy", 128'(busy), 128'(0));
    check("mid_reset_wkey", wkey, 128'(0));
    check("mid_reset_waddr", 128'(waddr), 128'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_idle();
    launch(k128, 1'b0);
    wait_done(13, 1'b0, "post_reset_done_latency");

    // Randomized keys, lengths, gaps and stray starts
    for (int i = 0; i < 20; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      len = bit'($urandom_range(0, 1));
      launch(rand256(), len);
      wait_done((len && HasAes256) ? 17 : 13, bit'($urandom_range(0, 1)), "rand_done_latency");
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_expander.md
# key_expander

Round-key generator that fills the 15-entry round-key store. It accepts a cipher key and a one-cycle `start` pulse, clears the store's valid bits, then writes one 128-bit round key per cycle to addresses 0..N. N is 10 for AES-128 and 14 for AES-256. It sits between the host key-load logic and the key memory, and is the sole driver of that memory's write port.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `key_len`  in  1  0 = AES-128, 1 = AES-256; sampled with `start`.
- `key_in`  in  256  cipher key, big-endian words. Word w0 = `key_in[255:224]`. AES-128 uses `key_in[255:128]`; the low half is ignored.
- `w_en`  out  1  key-memory write enable.
- `waddr`  out  4  key-memory write address (round index).
- `wkey`  out  128  round key; `wkey[127:96]` is the first word.
- `reset_valid_bits`  out  1  one-cycle clear of key-memory entries 1..14.
- `busy`  out  1  high from start acceptance until return to IDLE.
- `done`  out  1  one-cycle pulse after the last write.

## Operation
States and transitions:
- IDLE → CLEAR on `start`.
- CLEAR → EXPAND unconditionally.
- EXPAND → DONE after the write of round N.
- DONE → IDLE unconditionally.

Per-state behaviour:
- **IDLE:** on `start`, latch `key_in` into a 256-bit working register and latch `key_len`; round counter := 0; Rcon := 0x01.
- **CLEAR:** `reset_valid_bits` = 1, `w_en` = 0. Never assert both in the same cycle, because the memory gives the clear priority.
- **EXPAND:**
  - `w_en` = 1, `waddr` = round counter, `wkey` = current round key.
  - Counter increments each cycle; leave after the write with counter = N.
- **DONE:** `done` = 1 for one cycle.

Round keys:
- rk0 = w0..w3.
- AES-256 only: rk1 = w4..w7.
- Next-key generation:
  - AES-128: T = SubWord(RotWord(last word of rk(i-1))) ^ {Rcon,00,00,00}. New words chain by XOR onto rk(i-1): w0' = w0 ^ T, w1' = w1 ^ w0', and so on.
  - AES-256, even i ≥ 2: same T, XOR-chained onto rk(i-2).
  - AES-256, odd i ≥ 3: T = SubWord(last word of rk(i-1)) with no rotate and no Rcon, XOR-chained onto rk(i-2).
- Rcon advances by xtime (multiply by {02} in GF(2^8), reduce with 0x1B) after each use. Sequence: 01 02 04 08 10 20 40 80 1B 36.
- SubWord uses four instances of the team's combinational byte `sbox`.

Other rules:
- `start` in any state other than IDLE is ignored. `key_in` and `key_len` may change freely after acceptance.
- All outputs are decoded from registers only; there is no combinational path from inputs to outputs.

## Timing
Reset values:
- All outputs are 0: `w_en`, `waddr`, `wkey`, `reset_valid_bits`, `busy`, `done`.
- State is IDLE, Rcon = 0x01, working register = 0.

Cycle sequence, with edge E0 = start accepted:
- Cycle after E0: CLEAR.
- Cycles after E1..E(N+1): writes to addresses 0..N, one per cycle.
- Cycle after E(N+2): `done`.
- `busy` is high in CLEAR, EXPAND and DONE.

Latency:
- AES-128: 11 writes; `done` asserted 13 cycles after acceptance.
- AES-256: 15 writes; `done` asserted 17 cycles after acceptance.

Boundary conditions:
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. A partially written memory is left as-is; the next `start` clears it.
- `start` in the DONE cycle is ignored.
- `start` in the first IDLE cycle after DONE is accepted.
- `waddr` never exceeds 14. For AES-128 it never exceeds 10.

## Configuration
- `KEYEXP_AES256_EN` defined: `key_len` is honoured and AES-256 expansion (15 keys) is built in.
- `KEYEXP_AES256_EN` undefined:
  - `key_len` is ignored and treated as 0.
  - Only AES-128 logic is built.
  - The working register is 128 bits, loaded from `key_in[255:128]`.
  - Maximum `waddr` is 10.

## Test plan
- **Reset:** assert `reset` = 0 during EXPAND → all outputs 0 within the same cycle. Release, then `start` → full sequence from CLEAR.
- **AES-128 (FIPS-197 A.1):** key 2b7e151628aed2a6abf7158809cf4f3c, `key_len` = 0.
  - Required: one `reset_valid_bits` pulse.
  - Writes: addr 0 = key; addr 1 = a0fafe1788542cb123a339392a6c7605; addr 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` asserted 13 cycles after acceptance.
- **AES-256 (FIPS-197 A.3):** key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, `key_len` = 1.
  - Writes: addr 1 = 1f352c073b6108d72d9810a30914dff4; addr 2 = 9ba354118e6925afa51a8b5f2067fcde; addr 14 = fe4890d1e6188d0b046df344706c631e.
  - `done` asserted 17 cycles after acceptance.
- **Ignored start:** pulse `start` with a different key during EXPAND → write stream unchanged, single `done`.
- **Clear/write exclusion:** check `reset_valid_bits` & `w_en` is never 1 in any cycle. Check `waddr` increments by exactly 1 per write with no gaps.
- **Back-to-back:** AES-256 run, then AES-128 `start` in the first IDLE cycle → second CLEAR pulse, then 11 writes with correct AES-128 keys.
